sw_pe_scheduler: RTL and testbench

SW_PE_SCHEDULER -- requirements
Module: sw_pe_scheduler

---
 rtl/sw_pe_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sw_pe_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pe_scheduler.sv
// sw_pe_scheduler
//   Accepts one arranged REF/READ frame and cuts it into four overlapping
//   PE segments. It launches the four PEs and collects each PE's max/loc
//   result the first time that PE reports finish. It then starts the score
//   calculator and waits for it to complete. A RUN-cycle timer force-completes
//   a job whose PEs never all finish.
//
// Handshake: a frame transfers on a rising clk edge where frame_valid and
//   frame_ready are both high. frame_ready is high only in IDLE. In every
//   other state frame_valid is ignored and the latched segments stay stable.
//
// Ports
//   clk, rst_SC        clock, asynchronous active-high reset
//   frame_valid/ready  frame handshake
//   ref_in, read_in    arranged frames, TOTAL_WIDTH bits each
//   pe_start           one-cycle PE launch pulse
//   pe_ref, pe_read    four PE_WIDTH segments, slot k at [PE_WIDTH*k +: PE_WIDTH]
//   pe_finish          per-PE finish flags
//   pe_max, pe_loc     per-PE results (7 and 13 bits per slot)
//   sc_start           one-cycle score-calculator start pulse
//   sc_max, sc_loc     captured results, same layout as pe_max/pe_loc
//   sc_finish          score calculator done
//   busy               state != IDLE
//   timeout_err        sticky flag: last job was force-completed
//   state_dbg          current FSM state (debug observation)
module sw_pe_scheduler #(
    parameter int TOTAL_WIDTH = 252,
    parameter int PE_WIDTH    = 72,
    parameter int PE_SOLID    = 60,
    parameter int TIMEOUT     = 1023
) (
    input  logic                    clk,
    input  logic                    rst_SC,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [TOTAL_WIDTH-1:0]  ref_in,
    input  logic [TOTAL_WIDTH-1:0]  read_in,
    output logic                    pe_start,
    output logic [4*PE_WIDTH-1:0]   pe_ref,
    output logic [4*PE_WIDTH-1:0]   pe_read,
    input  logic [3:0]              pe_finish,
    input  logic [27:0]             pe_max,
    input  logic [51:0]             pe_loc,
    output logic                    sc_start,
    output logic [27:0]             sc_max,
    output logic [51:0]             sc_loc,
    input  logic                    sc_finish,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        RUN      = 3'd2,
        SC_START = 3'd3,
        SC_WAIT  = 3'd4
    } state_t;

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    state_t     state;
    logic [3:0] mask;
    logic [9:0] timer;
    logic       all_done;

    // Finish flags arriving in the current cycle count toward completion,
    // so the completing PE's data is captured on the same edge.
    assign all_done  = ((mask | pe_finish) == 4'hF);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst_SC) begin
        if (rst_SC) begin
            state       <= IDLE;
            frame_ready <= 1'b1;
            pe_start    <= 1'b0;
            sc_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            pe_ref      <= '0;
            pe_read     <= '0;
            sc_max      <= '0;
            sc_loc      <= '0;
            mask        <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        // Segment k starts PE_SOLID*k bits below the frame MSB.
                        for (int k = 0; k < 4; k++) begin
                            pe_ref[PE_WIDTH*k +: PE_WIDTH]  <= ref_in[TOTAL_WIDTH-1-PE_SOLID*k -: PE_WIDTH];
                            pe_read[PE_WIDTH*k +: PE_WIDTH] <= read_in[TOTAL_WIDTH-1-PE_SOLID*k -: PE_WIDTH];
                        end
                        timeout_err <= 1'b0;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                        pe_start    <= 1'b1;
                        state       <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    pe_start <= 1'b0;
                    mask     <= '0;
                    timer    <= '0;
                    state    <= RUN;
                end

                RUN: begin
                    timer <= timer + 10'd1;
                    // Capture each PE only on its first finish of this job.
                    for (int k = 0; k < 4; k++) begin
                        if (pe_finish[k] && !mask[k]) begin
                            mask[k]            <= 1'b1;
                            sc_max[7*k +: 7]   <= pe_max[7*k +: 7];
                            sc_loc[13*k +: 13] <= pe_loc[13*k +: 13];
                        end
                    end
                    if (all_done) begin
                        sc_start <= 1'b1;
                        state    <= SC_START;
                    end else if (timer == TIMEOUT_CNT) begin
                        // Forced completion: slots that never reported are zeroed.
                        for (int k = 0; k < 4; k++) begin
                            if (!(mask[k] || pe_finish[k])) begin
                                sc_max[7*k +: 7]   <= 7'd0;
                                sc_loc[13*k +: 13] <= 13'd0;
                            end
                        end
                        timeout_err <= 1'b1;
                        sc_start    <= 1'b1;
                        state       <= SC_START;
                    end
                end

                SC_START: begin
                    sc_start <= 1'b0;
                    state    <= SC_WAIT;
                end

                SC_WAIT: begin
                    if (sc_finish) begin
                        frame_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    frame_ready <= 1'b1;
                    busy        <= 1'b0;
                    pe_start    <= 1'b0;
                    sc_start    <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_pe_scheduler.sv
// Directed testbench for sw_pe_scheduler.
module tb_sw_pe_scheduler;

    logic          clk;
    logic          rst_SC;
    logic          frame_valid;
    logic          frame_ready;
    logic [251:0]  ref_in;
    logic [251:0]  read_in;
    logic          pe_start;
    logic [287:0]  pe_ref;
    logic [287:0]  pe_read;
    logic [3:0]    pe_finish;
    logic [27:0]   pe_max;
    logic [51:0]   pe_loc;
    logic          sc_start;
    logic [27:0]   sc_max;
    logic [51:0]   sc_loc;
    logic          sc_finish;
    logic          busy;
    logic          timeout_err;
    logic [2:0]    state_dbg;

    int tests_run;
    int tests_failed;

    logic [251:0] ref_a, read_a, ref_b, read_b;

    localparam logic [2:0] S_IDLE = 3'd0, S_LAUNCH = 3'd1, S_RUN = 3'd2,
                           S_SCST = 3'd3, S_SCWT = 3'd4;

    sw_pe_scheduler dut (
        .clk         (clk),
        .rst_SC      (rst_SC),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ref_in      (ref_in),
        .read_in     (read_in),
        .pe_start    (pe_start),
        .pe_ref      (pe_ref),
        .pe_read     (pe_read),
        .pe_finish   (pe_finish),
        .pe_max      (pe_max),
        .pe_loc      (pe_loc),
        .sc_start    (sc_start),
        .sc_max      (sc_max),
        .sc_loc      (sc_loc),
        .sc_finish   (sc_finish),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers. Inputs change on the falling edge; outputs are sampled there too.
    // Presents a frame and returns at the falling edge of the LAUNCH cycle.
    task automatic send_frame(input logic [251:0] r, input logic [251:0] d);
        int n;
        n = 0;
        frame_valid = 1'b1;
        ref_in      = r;
        read_in     = d;
        while (frame_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 50) begin
            tests_failed++;
            $display("FAIL frame_accept_wait: got no frame_ready in %0d cycles, required ready", n);
        end
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic pulse_sc_finish();
        sc_finish = 1'b1;
        @(negedge clk);
        sc_finish = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, pe_start, sc_start, timeout_err, frame_ready} !== 5'b00001) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 00001", {busy, pe_start, sc_start, timeout_err, frame_ready});
        end
        tests_run++;
        if (pe_ref !== '0 || pe_read !== '0 || sc_max !== '0 || sc_loc !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got ref %0h max %0h required 0", pe_ref, sc_max);
        end
        rst_SC = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state_dbg !== S_IDLE || frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got state %0d ready %b required 0/1", state_dbg, frame_ready);
        end
    endtask

    task automatic test_launch();
        tests_run++;
        if (pe_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL launch_pre: got pe_start %b required 0", pe_start);
        end
        send_frame(ref_a, read_a);
        tests_run++;
        if (pe_start !== 1'b1 || state_dbg !== S_LAUNCH || frame_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL launch_pulse: got start %b state %0d ready %b busy %b required 1/1/0/1",
                     pe_start, state_dbg, frame_ready, busy);
        end
        tests_run++;
        if (pe_ref[287:216] !== 72'h321FEDCBA987654321 || pe_ref[143:72] !== 72'h321FEDCBA987654321 ||
            pe_ref[71:0] !== 72'h321FEDCBA987654321 || pe_ref[215:144] !== 72'h321FEDCBA987654321) begin
            tests_failed++;
            $display("FAIL launch_pe_ref: got %0h required 4x 321fedcba987654321", pe_ref);
        end
        tests_run++;
        if (pe_read[71:0] !== 72'hEDCBA9876543210FED || pe_read[143:72] !== 72'hFEDCBA9876543210FE ||
            pe_read[215:144] !== 72'h0FEDCBA9876543210F || pe_read[287:216] !== 72'h10FEDCBA9876543210) begin
            tests_failed++;
            $display("FAIL launch_pe_read: got %0h required 10fedcba9876543210_0fedcba9876543210f_fedcba9876543210fe_edcba9876543210fed", pe_read);
        end
        @(negedge clk);
        tests_run++;
        if (pe_start !== 1'b0 || state_dbg !== S_RUN) begin
            tests_failed++;
            $display("FAIL launch_one_cycle: got start %b state %0d required 0/2", pe_start, state_dbg);
        end
    endtask

    // Continues the job launched by test_launch; entered at RUN cycle 1.
    task automatic test_finish_order();
        pe_loc    = {13'd103, 13'd102, 13'd101, 13'd100};
        pe_max    = {7'd13, 7'd12, 7'd11, 7'd10};
        pe_finish = 4'b0100;
        @(negedge clk);
        pe_finish = 4'b0001;
        @(negedge clk);
        // PE 2 pulses again with different data: must not be recaptured.
        pe_max    = {7'd13, 7'd99, 7'd11, 7'd10};
        pe_finish = 4'b1100;
        @(negedge clk);
        tests_run++;
        if (sc_start !== 1'b0 || state_dbg !== S_RUN) begin
            tests_failed++;
            $display("FAIL order_early: got sc_start %b state %0d required 0/2", sc_start, state_dbg);
        end
        pe_max    = {7'd13, 7'd12, 7'd11, 7'd10};
        pe_finish = 4'b0010;
        @(negedge clk);
        pe_finish = 4'b0000;
        tests_run++;
        if (sc_start !== 1'b1 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_sc_start: got sc_start %b terr %b required 1/0", sc_start, timeout_err);
        end
        tests_run++;
        if (sc_max !== {7'd13, 7'd12, 7'd11, 7'd10} || sc_loc !== {13'd103, 13'd102, 13'd101, 13'd100}) begin
            tests_failed++;
            $display("FAIL order_capture: got max %0h loc %0h required %0h %0h", sc_max, sc_loc,
                     {7'd13, 7'd12, 7'd11, 7'd10}, {13'd103, 13'd102, 13'd101, 13'd100});
        end
        @(negedge clk);
        tests_run++;
        if (sc_start !== 1'b0 || state_dbg !== S_SCWT) begin
            tests_failed++;
            $display("FAIL order_sc_pulse: got sc_start %b state %0d required 0/4", sc_start, state_dbg);
        end
        pulse_sc_finish();
        tests_run++;
        if (state_dbg !== S_IDLE || frame_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_idle: got state %0d ready %b busy %b required 0/1/0", state_dbg, frame_ready, busy);
        end
    endtask

    task automatic test_simultaneous();
        send_frame(ref_a, read_a);
        @(negedge clk);
        pe_max    = 28'hFFFFFFF;
        pe_loc    = {13'd4000, 13'd3000, 13'd2000, 13'd1000};
        pe_finish = 4'hF;
        @(negedge clk);
        pe_finish = 4'h0;
        tests_run++;
        if (sc_start !== 1'b1 || sc_max !== 28'hFFFFFFF || sc_loc !== {13'd4000, 13'd3000, 13'd2000, 13'd1000}) begin
            tests_failed++;
            $display("FAIL simul: got sc_start %b max %0h loc %0h required 1 fffffff", sc_start, sc_max, sc_loc);
        end
        @(negedge clk);
        pulse_sc_finish();
    endtask

    task automatic test_timeout();
        int n;
        send_frame(ref_a, read_a);
        @(negedge clk);
        pe_max    = {7'd5, 7'd3, 7'd2, 7'd1};
        pe_loc    = {13'd55, 13'd33, 13'd22, 13'd11};
        pe_finish = 4'b0111;
        @(negedge clk);
        pe_finish = 4'b0000;
        n = 1;
        while (sc_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 1024) begin
            tests_failed++;
            $display("FAIL timeout_cycles: got sc_start after %0d RUN cycles required 1024", n);
        end
        tests_run++;
        if (timeout_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_err: got %b required 1", timeout_err);
        end
        tests_run++;
        if (sc_max !== {7'd0, 7'd3, 7'd2, 7'd1} || sc_loc !== {13'd0, 13'd33, 13'd22, 13'd11}) begin
            tests_failed++;
            $display("FAIL timeout_slots: got max %0h loc %0h required %0h %0h", sc_max, sc_loc,
                     {7'd0, 7'd3, 7'd2, 7'd1}, {13'd0, 13'd33, 13'd22, 13'd11});
        end
        @(negedge clk);
        pulse_sc_finish();
        tests_run++;
        if (timeout_err !== 1'b1 || state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got terr %b state %0d required 1/0", timeout_err, state_dbg);
        end
    endtask

    task automatic test_reset_mid_job();
        send_frame(ref_a, read_a);
        tests_run++;
        if (timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL accept_clears_terr: got %b required 0", timeout_err);
        end
        @(negedge clk);
        pe_max    = {7'd0, 7'd0, 7'd0, 7'd42};
        pe_finish = 4'b0001;
        @(negedge clk);
        pe_finish = 4'b0000;
        @(negedge clk);
        rst_SC = 1'b1;
        #1;
        tests_run++;
        if ({busy, pe_start, sc_start, timeout_err} !== 4'b0000 || state_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL async_reset_flags: got %b state %0d required 0000/0",
                     {busy, pe_start, sc_start, timeout_err}, state_dbg);
        end
        tests_run++;
        if (pe_ref !== '0 || pe_read !== '0 || sc_max !== '0 || sc_loc !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_data: got ref %0h max %0h loc %0h required 0", pe_ref, sc_max, sc_loc);
        end
        @(negedge clk);
        tests_run++;
        if (sc_start !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_sc_start: got sc_start %b busy %b required 0/0", sc_start, busy);
        end
        rst_SC = 1'b0;
        @(negedge clk);
        send_frame(ref_a, read_a);
        @(negedge clk);
        pe_max    = {7'd4, 7'd3, 7'd2, 7'd1};
        pe_loc    = {13'd8, 13'd7, 13'd6, 13'd5};
        pe_finish = 4'hF;
        @(negedge clk);
        pe_finish = 4'h0;
        tests_run++;
        if (sc_start !== 1'b1 || sc_max !== {7'd4, 7'd3, 7'd2, 7'd1} || sc_loc !== {13'd8, 13'd7, 13'd6, 13'd5}) begin
            tests_failed++;
            $display("FAIL post_reset_job: got sc_start %b max %0h loc %0h required 1 %0h", sc_start, sc_max, sc_loc,
                     {7'd4, 7'd3, 7'd2, 7'd1});
        end
        @(negedge clk);
        pulse_sc_finish();
    endtask

    task automatic test_back_to_back();
        // pe_finish in IDLE must not touch the captured results.
        pe_max    = 28'h0;
        pe_loc    = 52'h0;
        pe_finish = 4'hF;
        @(negedge clk);
        pe_finish = 4'h0;
        tests_run++;
        if (sc_max !== {7'd4, 7'd3, 7'd2, 7'd1}) begin
            tests_failed++;
            $display("FAIL idle_pe_finish: got max %0h required %0h", sc_max, {7'd4, 7'd3, 7'd2, 7'd1});
        end
        send_frame(ref_a, read_a);
        @(negedge clk);
        sc_finish = 1'b1;
        @(negedge clk);
        sc_finish = 1'b0;
        tests_run++;
        if (state_dbg !== S_RUN || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL run_sc_finish_ignored: got state %0d busy %b required 2/1", state_dbg, busy);
        end
        pe_max    = {7'd20, 7'd21, 7'd22, 7'd23};
        pe_finish = 4'hF;
        @(negedge clk);
        pe_finish = 4'h0;
        @(negedge clk);
        // SC_WAIT: a valid frame must be ignored here.
        frame_valid = 1'b1;
        ref_in      = ref_b;
        read_in     = read_b;
        @(negedge clk);
        tests_run++;
        if (state_dbg !== S_SCWT || frame_ready !== 1'b0 || pe_ref[71:0] !== 72'h321FEDCBA987654321) begin
            tests_failed++;
            $display("FAIL scwait_frame_ignored: got state %0d ready %b slot0 %0h required 4/0/321fedcba987654321",
                     state_dbg, frame_ready, pe_ref[71:0]);
        end
        sc_finish = 1'b1;
        @(negedge clk);
        sc_finish = 1'b0;
        tests_run++;
        if (state_dbg !== S_IDLE || frame_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle: got state %0d ready %b required 0/1", state_dbg, frame_ready);
        end
        @(negedge clk);
        frame_valid = 1'b0;
        tests_run++;
        if (pe_start !== 1'b1 || pe_ref !== {4{72'hAAAAAAAAAAAAAAAAAA}} || pe_read !== {4{72'h555555555555555555}}) begin
            tests_failed++;
            $display("FAIL b2b_accept: got start %b ref %0h read %0h required 1 aaaa.. 5555..", pe_start, pe_ref, pe_read);
        end
        @(negedge clk);
        pe_finish = 4'hF;
        @(negedge clk);
        pe_finish = 4'h0;
        @(negedge clk);
        pulse_sc_finish();
        tests_run++;
        if (state_dbg !== S_IDLE || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_done: got state %0d busy %b required 0/0", state_dbg, busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_SC       = 1'b1;
        frame_valid  = 1'b0;
        ref_in       = '0;
        read_in      = '0;
        pe_finish    = 4'h0;
        pe_max       = '0;
        pe_loc       = '0;
        sc_finish    = 1'b0;
        for (int i = 0; i < 63; i++) begin
            ref_a[4*i +: 4]  = 4'((i % 15) + 1);
            read_a[4*i +: 4] = 4'(i % 16);
            ref_b[4*i +: 4]  = 4'hA;
            read_b[4*i +: 4] = 4'h5;
        end

        test_reset();
        test_launch();
        test_finish_order();
        test_simultaneous();
        test_timeout();
        test_reset_mid_job();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
